// File: rtl/boot_pkg.sv
// Shared boot state encoding and default parameters.
// The UART controller and the debug LEDs import this package as well.
package boot_pkg;

    typedef enum logic [2:0] {
        StFlush  = 3'd0,
        StIdle   = 3'd1,
        StTx99   = 3'd2,
        StRxSize = 3'd3,
        StRxProg = 3'd4,
        StTxAa   = 3'd5,
        StRun    = 3'd6,
        StError  = 3'd7
    } boot_state_t;

    localparam int unsigned DefaultResetHoldCycles = 4;
    localparam int unsigned DefaultRxTimeoutCycles = 100_000_000;
    localparam bit          DefaultAutoStart       = 1'b1;

endpackage

// File: rtl/boot_watchdog.sv
// Receive-inactivity watchdog: counts idle cycles while enabled and flags expiry.
// A zero timeout removes the expiry path entirely.
module boot_watchdog
    import boot_pkg::*;
#(
    parameter int unsigned RX_TIMEOUT_CYCLES = DefaultRxTimeoutCycles
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (!enable || clear) begin
            count_d = '0;
        end else begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    generate
        if (RX_TIMEOUT_CYCLES == 0) begin : g_disabled
            assign expire = 1'b0;
        end else begin : g_enabled
            localparam logic [31:0] Limit = 32'(RX_TIMEOUT_CYCLES - 1);
            // A kick or phase completion in the last cycle pre-empts expiry.
            assign expire = enable && !clear && (count_q == Limit);
        end
    endgenerate

endmodule

// File: rtl/boot_sequencer.sv
// Boot controller: sequences the UART program-load handshake, then hands the link
// to the running CPU. Owns the UART reset, CPU run enable, watchdog and reboot.
module boot_sequencer
    import boot_pkg::*;
#(
    parameter int unsigned RESET_HOLD_CYCLES = DefaultResetHoldCycles,
    parameter int unsigned RX_TIMEOUT_CYCLES = DefaultRxTimeoutCycles,
    parameter bit          AUTO_START        = DefaultAutoStart
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       boot_start,
    input  logic       rx_byte_strobe,
    input  logic       transmit_0x99_finished,
    input  logic       receive_program_data_size_finished,
    input  logic       receive_program_data_finished,
    input  logic       transmit_0xAA_finished,
    output logic       uart_reset_n,
    output logic       transmit_0x99,
    output logic       receive_program_data_size,
    output logic       receive_program_data,
    output logic       transmit_0xAA,
    output logic       receive_stdin_data,
    output logic       transmit_stdout_data,
    output logic       cpu_run,
    output logic       boot_error,
    output logic [2:0] boot_state
);

    localparam logic [2:0] S_FLUSH   = StFlush;
    localparam logic [2:0] S_IDLE    = StIdle;
    localparam logic [2:0] S_TX_99   = StTx99;
    localparam logic [2:0] S_RX_SIZE = StRxSize;
    localparam logic [2:0] S_RX_PROG = StRxProg;
    localparam logic [2:0] S_TX_AA   = StTxAa;
    localparam logic [2:0] S_RUN     = StRun;
    localparam logic [2:0] S_ERROR   = StError;

    localparam int unsigned      HoldW    = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             run_q, run_d;
    logic             error_q, error_d;
    logic             wd_enable, wd_clear, wd_expire, phase_done;

    // Completion of the current receive phase also restarts the watchdog for the next one.
    assign wd_enable  = (state_q == S_RX_SIZE) || (state_q == S_RX_PROG);
    assign phase_done = ((state_q == S_RX_SIZE) && receive_program_data_size_finished) ||
                        ((state_q == S_RX_PROG) && receive_program_data_finished);
    assign wd_clear   = rx_byte_strobe || phase_done;

    boot_watchdog #(
        .RX_TIMEOUT_CYCLES(RX_TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (wd_enable),
        .clear  (wd_clear),
        .expire (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FLUSH: begin
                if (hold_q == HoldLast) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (AUTO_START || boot_start) state_d = S_TX_99;
            end
            S_TX_99: begin
                if (transmit_0x99_finished) state_d = S_RX_SIZE;
            end
            S_RX_SIZE: begin
                if (receive_program_data_size_finished) state_d = S_RX_PROG;
                else if (wd_expire) state_d = S_ERROR;
            end
            S_RX_PROG: begin
                if (receive_program_data_finished) state_d = S_TX_AA;
                else if (wd_expire) state_d = S_ERROR;
            end
            S_TX_AA: begin
                if (transmit_0xAA_finished) state_d = S_RUN;
            end
            S_RUN, S_ERROR: begin
                if (boot_start) state_d = S_FLUSH;
            end
            default: state_d = S_FLUSH;
        endcase
    end

    // Hold counter idles at zero so every FLUSH entry starts a fresh hold window.
    always_comb begin
        hold_d = '0;
        if ((state_q == S_FLUSH) && (hold_q != HoldLast)) begin
            hold_d = hold_q + 1'b1;
        end
    end

    assign run_d   = (state_d == S_RUN);
    assign error_d = (state_d == S_ERROR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FLUSH;
            hold_q  <= '0;
            run_q   <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            run_q   <= run_d;
            error_q <= error_d;
        end
    end

    // Requests drop combinationally with their flag so a phase is never re-issued.
    assign uart_reset_n              = (state_q != S_FLUSH);
    assign transmit_0x99             = (state_q == S_TX_99) && !transmit_0x99_finished;
    assign receive_program_data_size = (state_q == S_RX_SIZE) &&
                                       !receive_program_data_size_finished;
    assign receive_program_data      = (state_q == S_RX_PROG) && !receive_program_data_finished;
    assign transmit_0xAA             = (state_q == S_TX_AA) && !transmit_0xAA_finished;

    assign receive_stdin_data   = run_q;
    assign transmit_stdout_data = run_q;
    assign cpu_run              = run_q;
    assign boot_error           = error_q;
    assign boot_state           = state_q;

endmodule
